// File: rtl/uart_dce_rx_fifo.sv
// uart_dce_rx_fifo: 8N1 UART receiver with divisor-set baud rate, FWFT byte FIFO and CTS flow control
module uart_dce_rx_fifo #(
   parameter int DATA_BITS     = 8,
   parameter int FIFO_DEPTH    = 16,
   parameter int CTS_THRESHOLD = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [31:0]                   dbr,
   input  logic                          rxd,
   output logic                          cts,
   output logic [DATA_BITS-1:0]          out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          frame_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
   state_t state, state_n;
   logic s1, rs;
   logic [31:0] per, per_n, cnt, cnt_n, pd;
   logic [IW-1:0] idx, idx_n;
   logic [DATA_BITS-1:0] sh, sh_n;
   logic push_req, ferr_n;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt_f, cnt_f_n;
   logic full, pop, push;
   assign pd = (dbr < 32'd2) ? 32'd2 : dbr;
   always_comb begin
      state_n  = state;
      per_n    = per;
      cnt_n    = (cnt == 32'd0) ? cnt : cnt - 32'd1;
      idx_n    = idx;
      sh_n     = sh;
      push_req = 1'b0;
      ferr_n   = 1'b0;
      case (state)
         IDLE: if (!rs) begin
            per_n   = pd;
            cnt_n   = (pd >> 1) - 32'd1;
            state_n = START;
         end
         START: if (cnt == 32'd0) begin
            state_n = rs ? IDLE : DATA;
            cnt_n   = per - 32'd1;
            idx_n   = '0;
         end
         DATA: if (cnt == 32'd0) begin
            sh_n    = {rs, sh[DATA_BITS-1:1]};
            cnt_n   = per - 32'd1;
            idx_n   = idx + 1'b1;
            state_n = (idx == IW'(DATA_BITS-1)) ? STOP : DATA;
         end
         STOP: if (cnt == 32'd0) begin
            push_req = rs;
            ferr_n   = !rs;
            state_n  = rs ? IDLE : WAIT_HIGH;
         end
         WAIT_HIGH: state_n = rs ? IDLE : WAIT_HIGH;
         default: state_n = IDLE;
      endcase
   end
   assign out_valid  = cnt_f != '0;
   assign full       = cnt_f == (AW+1)'(FIFO_DEPTH);
   assign pop        = out_valid & out_ready;
   // a full FIFO still accepts a byte when the head leaves on the same edge
   assign push       = push_req & (!full | pop);
   assign cnt_f_n    = cnt_f + (AW+1)'(push) - (AW+1)'(pop);
   assign out_data   = out_valid ? mem[rp] : '0;
   assign fifo_count = cnt_f;
   always_ff @(posedge clock)
      if (push) mem[wp] <= sh;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1        <= 1'b1;
         rs        <= 1'b1;
         state     <= IDLE;
         per       <= 32'd2;
         cnt       <= '0;
         idx       <= '0;
         sh        <= '0;
         wp        <= '0;
         rp        <= '0;
         cnt_f     <= '0;
         cts       <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         s1        <= rxd;
         rs        <= s1;
         state     <= state_n;
         per       <= per_n;
         cnt       <= cnt_n;
         idx       <= idx_n;
         sh        <= sh_n;
         wp        <= push ? wp + 1'b1 : wp;
         rp        <= pop ? rp + 1'b1 : rp;
         cnt_f     <= cnt_f_n;
         cts       <= cnt_f_n <= (AW+1)'(FIFO_DEPTH - CTS_THRESHOLD);
         frame_err <= ferr_n;
         overrun   <= push_req & full & !pop;
      end
   end
endmodule

// File: tb/tb_uart_dce_rx_fifo.sv
// tb_uart_dce_rx_fifo: directed frame table plus hand-written FIFO full, overrun and reset sequences
module tb_uart_dce_rx_fifo;
   logic clock = 1'b0, reset = 1'b0, rxd = 1'b1, out_ready = 1'b0;
   logic [31:0] dbr = 32'd10;
   logic cts, out_valid, frame_err, overrun;
   logic [7:0] out_data;
   logic [4:0] fifo_count;
   int vec = 0, bad = 0, cyc = 0, st = 0, last_rise = 0, ferr_cnt = 0, ovr_cnt = 0, vcnt = 0;
   logic pv = 1'b0;
   logic [7:0] got [$];
   typedef struct {
      int kind; int d; int p; logic [7:0] b; bit stopb; int hold;
      int en; logic [7:0] ed; int ef; int el;
   } vec_t;
   vec_t tv [9];
   uart_dce_rx_fifo dut (
      .clock(clock), .reset(reset), .dbr(dbr), .rxd(rxd), .cts(cts),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_err(frame_err), .overrun(overrun), .fifo_count(fifo_count)
   );
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;
   always @(negedge clock) begin
      if (out_valid && out_ready) got.push_back(out_data);
      if (out_valid && !pv) last_rise = cyc;
      if (out_valid) vcnt++;
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      pv = out_valid;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   task automatic chk(input string name, input int act, input int exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask
   task automatic send_frame(input logic [7:0] b, input bit stopb, input int p, input int hold);
      @(posedge clock); #1 rxd = 1'b0; st = cyc;
      repeat (p) @(posedge clock);
      for (int i = 0; i < 8; i++) begin
         #1 rxd = b[i];
         repeat (p) @(posedge clock);
      end
      #1 rxd = stopb;
      repeat (p + hold) @(posedge clock);
      #1 rxd = 1'b1;
   endtask
   initial begin
      int g0, f0, o0, v0;
      tv[0] = '{0, 10, 10, 8'hA5, 1'b1, 0,  1, 8'hA5, 0, 98};
      tv[1] = '{1, 10, 10, 8'h00, 1'b1, 0,  0, 8'h00, 0, 0};
      tv[2] = '{0, 10, 10, 8'h5A, 1'b1, 0,  1, 8'h5A, 0, 98};
      tv[3] = '{0, 10, 10, 8'h3C, 1'b0, 20, 0, 8'h00, 1, 0};
      tv[4] = '{0, 10, 10, 8'h11, 1'b1, 0,  1, 8'h11, 0, 98};
      tv[5] = '{0, 3,  3,  8'hC3, 1'b1, 0,  1, 8'hC3, 0, 31};
      tv[6] = '{0, 2,  2,  8'h0F, 1'b1, 0,  1, 8'h0F, 0, 22};
      tv[7] = '{0, 1,  2,  8'hF0, 1'b1, 0,  1, 8'hF0, 0, 22};
      tv[8] = '{0, 0,  2,  8'h81, 1'b1, 0,  1, 8'h81, 0, 22};
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst cts", cts, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst count", fifo_count, 0);
      chk("rst out_data", out_data, 0);
      chk("rst frame_err", frame_err, 0);
      chk("rst overrun", overrun, 0);
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); @(negedge clock);
      chk("cts after release", cts, 1);
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         g0 = got.size(); f0 = ferr_cnt; o0 = ovr_cnt; v0 = vcnt;
         @(posedge clock); #1 dbr = tv[k].d;
         if (tv[k].kind == 1) begin
            @(posedge clock); #1 rxd = 1'b0;
            repeat (3) @(posedge clock);
            #1 rxd = 1'b1;
         end else send_frame(tv[k].b, tv[k].stopb, tv[k].p, tv[k].hold);
         repeat (3 * tv[k].p + 12) @(posedge clock);
         @(negedge clock);
         chk($sformatf("v%0d pushes", k), got.size() - g0, tv[k].en);
         chk($sformatf("v%0d valid cycles", k), vcnt - v0, tv[k].en);
         chk($sformatf("v%0d frame_err", k), ferr_cnt - f0, tv[k].ef);
         chk($sformatf("v%0d overrun", k), ovr_cnt - o0, 0);
         if (tv[k].en == 1 && got.size() > g0) begin
            chk($sformatf("v%0d data", k), got[g0], tv[k].ed);
            chk($sformatf("v%0d latency", k), last_rise - st, tv[k].el);
         end
      end
      // fill to full with no consumer, then overrun on the 17th byte
      out_ready = 1'b0; dbr = 32'd4;
      for (int i = 0; i < 16; i++) begin
         send_frame(8'(i), 1'b1, 4, 0);
         repeat (6) @(posedge clock);
         @(negedge clock);
         chk($sformatf("fill%0d count", i), fifo_count, i + 1);
         chk($sformatf("fill%0d cts", i), cts, (i + 1 <= 12) ? 1 : 0);
      end
      o0 = ovr_cnt;
      send_frame(8'h10, 1'b1, 4, 0);
      repeat (6) @(posedge clock);
      @(negedge clock);
      chk("overrun pulse", ovr_cnt - o0, 1);
      chk("overrun count", fifo_count, 16);
      chk("overrun head", out_data, 8'h00);
      g0 = got.size();
      @(posedge clock); #1 out_ready = 1'b1;
      repeat (20) @(posedge clock);
      #1 out_ready = 1'b0;
      @(negedge clock);
      chk("drain count", got.size() - g0, 16);
      for (int i = 0; i < 16; i++)
         if (g0 + i < got.size()) chk($sformatf("drain%0d", i), got[g0 + i], i);
      chk("drained empty", fifo_count, 0);
      // full FIFO with a pop on the same edge as the final push
      for (int i = 0; i < 16; i++) begin
         send_frame(8'(i), 1'b1, 4, 0);
         repeat (4) @(posedge clock);
      end
      @(negedge clock);
      chk("refill count", fifo_count, 16);
      g0 = got.size(); o0 = ovr_cnt;
      fork
         send_frame(8'h20, 1'b1, 4, 0);
         begin
            @(posedge clock); #1;
            repeat (40) @(posedge clock);
            #1 out_ready = 1'b1;
            @(posedge clock); #1 out_ready = 1'b0;
            @(negedge clock);
            chk("coinc count", fifo_count, 16);
            chk("coinc head", out_data, 8'h01);
         end
      join
      repeat (6) @(posedge clock);
      chk("coinc no overrun", ovr_cnt - o0, 0);
      @(posedge clock); #1 out_ready = 1'b1;
      repeat (20) @(posedge clock);
      #1 out_ready = 1'b0;
      @(negedge clock);
      chk("coinc pops", got.size() - g0, 17);
      for (int i = 0; i < 17; i++)
         if (g0 + i < got.size()) chk($sformatf("coinc%0d", i), got[g0 + i], (i < 16) ? i : 8'h20);
      // reset in the middle of a frame with one byte queued
      dbr = 32'd10;
      send_frame(8'h77, 1'b1, 10, 0);
      repeat (10) @(posedge clock);
      @(negedge clock);
      chk("pre-reset count", fifo_count, 1);
      @(posedge clock); #1 rxd = 1'b0;
      repeat (10) @(posedge clock);
      #1 rxd = 1'b1;
      repeat (20) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("midrst out_valid", out_valid, 0);
      chk("midrst count", fifo_count, 0);
      chk("midrst cts", cts, 0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock); @(negedge clock);
      chk("midrst cts release", cts, 1);
      g0 = got.size(); f0 = ferr_cnt;
      out_ready = 1'b1;
      fork
         send_frame(8'h96, 1'b1, 10, 0);
         begin
            @(posedge clock);
            repeat (50) @(posedge clock);
            #1 dbr = 32'd20;
         end
      join
      repeat (20) @(posedge clock);
      @(negedge clock);
      chk("dbr change pushes", got.size() - g0, 1);
      if (got.size() > g0) chk("dbr change data", got[g0], 8'h96);
      chk("dbr change latency", last_rise - st, 98);
      chk("dbr change frame_err", ferr_cnt - f0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end
endmodule
